// File: rtl/toggle_event_gen.sv
// Per-bit toggle-completion detector feeding a toggle cover sink: one-cycle valid pulses plus sticky coverage count.
// Optional macro TOGGLE_EVENT_GEN_STAMP_EN adds a free-running cycle counter and last_hit_cycle output.
module toggle_event_gen #(
  parameter int WIDTH    = 4,
  parameter int ONE_SHOT = 1,
  parameter int CNT_W    = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
`ifdef TOGGLE_EVENT_GEN_STAMP_EN
  output logic [31:0]      last_hit_cycle,
`endif
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] done_q, done_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_q, all_d;

  logic [WIDTH-1:0] rise, fall, rs_n, fs_n, comp;

  assign rise = sig & ~prev_q;
  assign fall = ~sig & prev_q;
  assign rs_n = rise_q | rise;
  assign fs_n = fall_q | fall;
  assign comp = rs_n & fs_n;

  always_comb begin
    prev_d   = sig;
    rise_d   = rise_q;
    fall_d   = fall_q;
    done_d   = done_q;
    primed_d = primed_q;
    valid_d  = '0;
    if (clear) begin
      rise_d   = '0;
      fall_d   = '0;
      done_d   = '0;
      primed_d = 1'b0;
    end else if (en) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (ONE_SHOT != 0) begin
        valid_d = comp & ~done_q;
        done_d  = done_q | comp;
        rise_d  = rs_n;
        fall_d  = fs_n;
      end else begin
        // Completed bits re-arm so the next rise+fall pair pulses again.
        valid_d = comp;
        done_d  = done_q | comp;
        rise_d  = rs_n & ~comp;
        fall_d  = fs_n & ~comp;
      end
    end
    cnt_d = popcnt(done_d);
    all_d = &done_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      done_q   <= '0;
      primed_q <= 1'b0;
      valid_q  <= '0;
      cnt_q    <= '0;
      all_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      done_q   <= done_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      all_q    <= all_d;
    end
  end

  assign valid       = valid_q;
  assign covered_cnt = cnt_q;
  assign all_covered = all_q;

`ifdef TOGGLE_EVENT_GEN_STAMP_EN
  logic [31:0] cycle_ctr_q, cycle_ctr_d;
  logic [31:0] last_hit_q, last_hit_d;

  always_comb begin
    cycle_ctr_d = cycle_ctr_q + 32'd1;
    last_hit_d  = last_hit_q;
    if (clear) last_hit_d = '0;
    else if (cnt_d > cnt_q) last_hit_d = cycle_ctr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_ctr_q <= '0;
      last_hit_q  <= '0;
    end else begin
      cycle_ctr_q <= cycle_ctr_d;
      last_hit_q  <= last_hit_d;
    end
  end

  assign last_hit_cycle = last_hit_q;
`endif

endmodule

// File: tb/tb_toggle_event_gen.sv
// Directed bench for toggle_event_gen: a ONE_SHOT=1 and a ONE_SHOT=0 instance share stimulus; a reference model feeds a scoreboard.
module tb_toggle_event_gen;

  logic       clock = 1'b0;
  logic       reset, en, clear;
  logic [3:0] sig;
  logic [3:0] valid1, valid0;
  logic [2:0] cnt1, cnt0;
  logic       all1, all0;
`ifdef TOGGLE_EVENT_GEN_STAMP_EN
  logic [31:0] hit1, hit0;
`endif

  always #5 clock = ~clock;

  toggle_event_gen #(.WIDTH(4), .ONE_SHOT(1)) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .sig(sig),
    .valid(valid1),
`ifdef TOGGLE_EVENT_GEN_STAMP_EN
    .last_hit_cycle(hit1),
`endif
    .covered_cnt(cnt1), .all_covered(all1));

  toggle_event_gen #(.WIDTH(4), .ONE_SHOT(0)) dut_rep (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .sig(sig),
    .valid(valid0),
`ifdef TOGGLE_EVENT_GEN_STAMP_EN
    .last_hit_cycle(hit0),
`endif
    .covered_cnt(cnt0), .all_covered(all0));

  typedef struct packed {
    logic [3:0] v1; logic [2:0] c1; logic a1;
    logic [3:0] v0; logic [2:0] c0; logic a0;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state, index 1 = one-shot instance, 0 = repeating instance
  logic [3:0] m_prev[2], m_rise[2], m_fall[2], m_done[2];
  logic       m_primed[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_prev[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_done[m] = '0; m_primed[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input logic e, input logic c, input logic [3:0] s,
                            output logic [3:0] v, output logic [2:0] cnt, output logic a);
    v = '0;
    for (int i = 0; i < 4; i++) begin
      logic r, f, rs, fs, cp;
      if (c) begin
        m_rise[m][i] = 0; m_fall[m][i] = 0; m_done[m][i] = 0;
      end else if (e && m_primed[m]) begin
        r  = s[i] && !m_prev[m][i];
        f  = !s[i] && m_prev[m][i];
        rs = m_rise[m][i] || r;
        fs = m_fall[m][i] || f;
        cp = rs && fs;
        if (m == 1) begin
          v[i] = cp && !m_done[m][i];
          m_rise[m][i] = rs; m_fall[m][i] = fs;
        end else begin
          v[i] = cp;
          m_rise[m][i] = cp ? 1'b0 : rs;
          m_fall[m][i] = cp ? 1'b0 : fs;
        end
        if (cp) m_done[m][i] = 1'b1;
      end
    end
    if (c) m_primed[m] = 1'b0;
    else if (e) m_primed[m] = 1'b1;
    m_prev[m] = s;
    cnt = 3'(m_done[m][0]) + 3'(m_done[m][1]) + 3'(m_done[m][2]) + 3'(m_done[m][3]);
    a = (m_done[m] == 4'b1111);
  endtask

  task automatic score();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk("sb_valid1", 32'(valid1), 32'(x.v1));
      chk("sb_cnt1",   32'(cnt1),   32'(x.c1));
      chk("sb_all1",   32'(all1),   32'(x.a1));
      chk("sb_valid0", 32'(valid0), 32'(x.v0));
      chk("sb_cnt0",   32'(cnt0),   32'(x.c0));
      chk("sb_all0",   32'(all0),   32'(x.a0));
    end
  endtask

  task automatic cyc(input logic e, input logic c, input logic [3:0] s);
    exp_t x;
    en = e; clear = c; sig = s; reset = 1'b0;
    model_step(1, e, c, s, x.v1, x.c1, x.a1);
    model_step(0, e, c, s, x.v0, x.c0, x.a0);
    sb.push_back(x);
    @(posedge clock); #1;
    score();
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; clear = 1'b0; sig = 4'b0101;
    model_reset();
    sb.push_back('0);
    @(posedge clock); #1;
    score();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clear = 1'b0; sig = '0;
    model_reset();
    @(posedge clock); #1;
    do_reset();
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_cnt",   32'(cnt1),   32'd0);
    chk("rst_all",   32'(all1),   32'd0);

    // First enabled sample only primes
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 4'b0000);
      chk("prime_valid", 32'(valid1), 32'd0);
    end
    chk("prime_cnt", 32'(cnt1), 32'd0);

    // bit0 rise then fall two samples later
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0001);
    chk("b0_nopulse_yet", 32'(valid1), 32'd0);
    cyc(1, 0, 4'b0000);
    chk("b0_pulse",  32'(valid1), 32'b0001);
    chk("b0_cnt",    32'(cnt1),   32'd1);
    cyc(1, 0, 4'b0000);
    chk("b0_one_cycle", 32'(valid1), 32'd0);
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0000);
    chk("b0_oneshot_repeat", 32'(valid1), 32'd0);
    chk("b0_rep_repeat",     32'(valid0), 32'b0001);
    chk("b0_rep_cnt",        32'(cnt0),   32'd1);

    // Re-arm, then bit2 toggles twice
    cyc(0, 1, 4'b0000);
    chk("clr_cnt", 32'(cnt0), 32'd0);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0100);
    cyc(1, 0, 4'b0000);
    chk("b2_rep_pulse1", 32'(valid0), 32'b0100);
    cyc(1, 0, 4'b0100);
    chk("b2_rep_gap", 32'(valid0), 32'd0);
    cyc(1, 0, 4'b0000);
    chk("b2_rep_pulse2", 32'(valid0), 32'b0100);
    chk("b2_rep_cnt",    32'(cnt0),   32'd1);
    chk("b2_oneshot_2nd", 32'(valid1), 32'd0);

    // All bits together
    cyc(1, 0, 4'b1111);
    cyc(1, 0, 4'b0000);
    chk("all_rep_valid", 32'(valid0), 32'b1111);
    chk("all_os_valid",  32'(valid1), 32'b1011);
    chk("all_cnt",       32'(cnt1),   32'd4);
    chk("all_covered",   32'(all1),   32'd1);

    // Disabled transitions are dropped; clear beats a completion
    cyc(0, 1, 4'b0000);
    chk("clr_all", 32'(all1), 32'd0);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0000);
    chk("pre_cnt", 32'(cnt1), 32'd1);
    cyc(0, 0, 4'b0010);
    cyc(0, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    chk("en0_nopulse", 32'(valid1), 32'd0);
    cyc(1, 0, 4'b1000);
    cyc(1, 1, 4'b0000);
    chk("clr_en_valid", 32'(valid1), 32'd0);
    chk("clr_en_cnt",   32'(cnt1),   32'd0);
    cyc(1, 0, 4'b1000);
    chk("after_clr_prime", 32'(valid1), 32'd0);
    cyc(1, 0, 4'b0000);
    chk("after_clr_fall", 32'(valid1), 32'd0);
    cyc(1, 0, 4'b1000);
    chk("b3_complete", 32'(valid1), 32'b1000);
    chk("b3_cnt",      32'(cnt1),   32'd1);

`ifdef TOGGLE_EVENT_GEN_STAMP_EN
    do_reset();
    chk("stamp_rst", hit1, 32'd0);
    cyc(1, 0, 4'b0000);
    for (int k = 0; k < 4; k++) cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0000);
    chk("stamp_hit", hit1, 32'd7);
    force dut.cycle_ctr_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_ctr_q;
    chk("ctr_forced", dut.cycle_ctr_q, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    chk("ctr_wrap", dut.cycle_ctr_q, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
